// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the access legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } lsu_state_e;

  // 1 when the access must be rejected without touching memory.
  function automatic logic access_bad(input logic [2:0] funct3, input logic write,
                                      input logic [1:0] off);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = off[0];
      F3_W:    bad = (off != 2'b00);
      F3_BU:   bad = write;
      F3_HU:   bad = write | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane logic: extracts/extends load data and merges sub-word store data into
// an existing memory word. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] load_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign shifted  = load_word >> {off, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = off[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    load_val = load_word;
    case (funct3)
      F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_val = {24'h0, byte_sel};
      F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_val = {16'h0, half_sel};
      default: load_val = load_word;
    endcase
  end

  // Each byte lane takes new data only when the access covers it.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic hit_b;
    logic hit_h;
    assign hit_b = (funct3 == F3_B) && (off == LANE);
    assign hit_h = (funct3 == F3_H) && (off[1] == LANE[1]);
    assign store_word[8*gi +: 8] = (funct3 == F3_W) ? wdata[8*gi +: 8] :
                                   hit_b            ? wdata[7:0] :
                                   hit_h            ? wdata[8*(gi%2) +: 8] :
                                                      old_word[8*gi +: 8];
  end

endmodule

// File: rtl/load_store_unit.sv
// Sequential load/store unit: one byte/half/word access per request, with
// read-modify-write for sub-word stores so memory only sees aligned words.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [31:0]           resp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [31:0]           mem_dout
);

  lsu_state_e            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            funct3_q;
  logic                  write_q;
  logic [31:0]           wdata_q;
  logic [31:0]           merged_q;
  logic [31:0]           rdata_q;
  logic                  err_q;

  logic [31:0] load_val;
  logic [31:0] store_word;

  lsu_align u_align (
    .load_word  (mem_dout),
    .old_word   (mem_dout),
    .wdata      (wdata_q),
    .off        (addr_q[1:0]),
    .funct3     (funct3_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      funct3_q <= 3'b000;
      write_q  <= 1'b0;
      wdata_q  <= 32'h0;
      merged_q <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            write_q  <= req_write;
            wdata_q  <= req_wdata;
            if (access_bad(req_funct3, req_write, req_addr[1:0])) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              err_q <= 1'b0;
              // A full-word store needs no old data, so skip the read.
              if (req_write && req_funct3 == F3_W) begin
                merged_q <= req_wdata;
                state_q  <= S_WRITE;
              end else begin
                state_q <= S_READ;
              end
            end
          end
        end
        S_READ: begin
          if (write_q) begin
            merged_q <= store_word;
            state_q  <= S_WRITE;
          end else begin
            rdata_q <= load_val;
            state_q <= S_DONE;
          end
        end
        S_WRITE: state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = rdata_q;
  assign mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_din    = merged_q;
  assign mem_read   = (state_q == S_READ);
  // Reset must suppress a write in the same cycle so a dropped RMW never lands.
  assign mem_write  = (state_q == S_WRITE) && !reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written corner
// sequences and random traffic against a word-array memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];
  logic [31:0] model_mem [0:63];
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_dout   (mem_dout)
  );

  assign mem_dout = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_din;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          reads;
    int          writes;
    logic [31:0] din;
  } vec_t;

  vec_t vecs [0:14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour from the access rules: legality, size, lanes, extension.
  task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output vec_t e);
    int size;
    bit legal;
    logic [31:0] w, v, mask;
    int sh;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = wr ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (addr % size != 0) legal = 0;
    sh = 8 * int'(addr % 4);
    w = model_mem[addr[7:2]];
    e.wr = wr; e.f3 = f3; e.addr = addr; e.wdata = wdata;
    e.err = !legal; e.reads = 0; e.writes = 0; e.din = 32'h0;
    if (!legal) begin
      e.lat = 1;
    end else if (!wr) begin
      e.lat = 2; e.reads = 1;
      v = w >> sh;
      if (size == 1) begin
        v = v & 32'hFF;
        if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      end
      model_rdata = v;
    end else begin
      e.writes = 1;
      e.reads = (size == 4) ? 0 : 1;
      e.lat = (size == 4) ? 2 : 3;
      mask = (size == 4) ? 32'hFFFF_FFFF : (size == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
      mask = mask << sh;
      e.din = (w & ~mask) | ((wdata << sh) & mask);
      model_mem[addr[7:2]] = e.din;
    end
    e.rdata = model_rdata;
  endtask

  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output vec_t a);
    int w;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    a.wr = wr; a.f3 = f3; a.addr = addr; a.wdata = wdata;
    a.lat = 1; a.reads = 0; a.writes = 0; a.din = 32'h0;
    while (a.lat < 12) begin
      if (mem_read) begin
        a.reads++;
        chk("mem_addr_rd", mem_addr, {addr[31:2], 2'b00});
      end
      if (mem_write) begin
        a.writes++;
        a.din = mem_din;
        chk("mem_addr_wr", mem_addr, {addr[31:2], 2'b00});
      end
      if (mem_read && mem_write) chk("rd_wr_excl", {31'b0, mem_read & mem_write}, 32'd0);
      if (resp_valid) break;
      @(negedge clk);
      a.lat++;
    end
    chk("resp_seen", {31'b0, resp_valid}, 32'd1);
    a.err = resp_err;
    a.rdata = resp_rdata;
  endtask

  task automatic compare(input string tag, input vec_t a, input vec_t e);
    $display("%s wr=%0b f3=%0d addr=%h wdata=%h -> err=%0b rdata=%h lat=%0d rd=%0d wr=%0d din=%h",
             tag, a.wr, a.f3, a.addr, a.wdata, a.err, a.rdata, a.lat, a.reads, a.writes, a.din);
    chk({tag, " err"}, {31'b0, a.err}, {31'b0, e.err});
    chk({tag, " rdata"}, a.rdata, e.rdata);
    chk({tag, " latency"}, a.lat, e.lat);
    chk({tag, " reads"}, a.reads, e.reads);
    chk({tag, " writes"}, a.writes, e.writes);
    if (e.writes != 0) begin
      chk({tag, " mem_din"}, a.din, e.din);
      chk({tag, " mem_word"}, mem[e.addr[7:2]], e.din);
    end
  endtask

  initial begin
    vec_t act, exp_m;
    int n;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'h0101_0101 * i ^ 32'hA5C3_5A3C;
    end
    mem[4]  = 32'h8765_4321;
    mem[8]  = 32'h1122_3344;
    mem[12] = 32'h1122_3344;
    mem[20] = 32'h5566_7788;
    for (int i = 0; i < 64; i++) model_mem[i] = mem[i];
    model_rdata = 32'h0;

    //           wr    f3      addr         wdata         err   rdata         lat rd wr din
    vecs[0]  = '{1'b0, 3'b010, 32'h10, 32'h0,          1'b0, 32'h8765_4321, 2, 1, 0, 32'h0};
    vecs[1]  = '{1'b0, 3'b000, 32'h13, 32'h0,          1'b0, 32'hFFFF_FF87, 2, 1, 0, 32'h0};
    vecs[2]  = '{1'b0, 3'b100, 32'h13, 32'h0,          1'b0, 32'h0000_0087, 2, 1, 0, 32'h0};
    vecs[3]  = '{1'b0, 3'b001, 32'h12, 32'h0,          1'b0, 32'hFFFF_8765, 2, 1, 0, 32'h0};
    vecs[4]  = '{1'b0, 3'b101, 32'h12, 32'h0,          1'b0, 32'h0000_8765, 2, 1, 0, 32'h0};
    vecs[5]  = '{1'b1, 3'b000, 32'h21, 32'h1234_56AB,  1'b0, 32'h0000_8765, 3, 1, 1, 32'h1122_AB44};
    vecs[6]  = '{1'b1, 3'b001, 32'h32, 32'h5555_BEEF,  1'b0, 32'h0000_8765, 3, 1, 1, 32'hBEEF_3344};
    vecs[7]  = '{1'b0, 3'b010, 32'h06, 32'h0,          1'b1, 32'h0000_8765, 1, 0, 0, 32'h0};
    vecs[8]  = '{1'b1, 3'b001, 32'h05, 32'h1234,       1'b1, 32'h0000_8765, 1, 0, 0, 32'h0};
    vecs[9]  = '{1'b0, 3'b011, 32'h10, 32'h0,          1'b1, 32'h0000_8765, 1, 0, 0, 32'h0};
    vecs[10] = '{1'b1, 3'b010, 32'h44, 32'hCAFE_F00D,  1'b0, 32'h0000_8765, 2, 0, 1, 32'hCAFE_F00D};
    vecs[11] = '{1'b0, 3'b010, 32'h44, 32'h0,          1'b0, 32'hCAFE_F00D, 2, 1, 0, 32'h0};
    vecs[12] = '{1'b1, 3'b100, 32'h20, 32'hFF,         1'b1, 32'hCAFE_F00D, 1, 0, 0, 32'h0};
    vecs[13] = '{1'b0, 3'b000, 32'h20, 32'h0,          1'b0, 32'h0000_0044, 2, 1, 0, 32'h0};
    vecs[14] = '{1'b0, 3'b001, 32'h20, 32'h0,          1'b0, 32'hFFFF_AB44, 2, 1, 0, 32'h0};

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_din", mem_din, 32'h0);
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      model(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, exp_m);
      do_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, act);
      compare($sformatf("vec%0d", i), act, vecs[i]);
    end

    // Reset while an SB is in its write cycle: write suppressed, no response.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h50; req_wdata = 32'h99;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rmw mem_write before reset", {31'b0, mem_write}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rmw mem_write during reset", {31'b0, mem_write}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_rdata = 32'h0;
    #1;
    $display("reset-during-write: ready=%0b resp_valid=%0b word=%h", req_ready, resp_valid, mem[20]);
    chk("rmw ready after reset", {31'b0, req_ready}, 32'd1);
    chk("rmw word unchanged", mem[20], 32'h5566_7788);
    for (int i = 0; i < 3; i++) begin
      chk("rmw no resp", {31'b0, resp_valid}, 32'd0);
      @(negedge clk);
    end

    // Back-to-back with req_valid held continuously.
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h40; req_wdata = 32'hDEAD_BEEF;
    model(1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, exp_m);
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    chk("b2b first resp", {31'b0, resp_valid}, 32'd1);
    req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
    model(1'b0, 3'b010, 32'h40, 32'h0, exp_m);
    @(negedge clk);
    chk("b2b ready after resp", {31'b0, req_ready}, 32'd1);
    n = 0;
    @(negedge clk); n++;
    req_valid = 1'b0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    $display("back-to-back: second resp after %0d cycles rdata=%h", n, resp_rdata);
    chk("b2b second latency", n, 32'd2);
    chk("b2b rdata", resp_rdata, 32'hDEAD_BEEF);
    chk("b2b mem word", mem[16], 32'hDEAD_BEEF);

    // Random traffic against the reference model.
    for (int i = 0; i < 150; i++) begin
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr, wdata;
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) addr = addr & 32'hFFFF_FFFC;
      wdata = $urandom;
      model(wr, f3, addr, wdata, exp_m);
      do_req(wr, f3, addr, wdata, act);
      compare($sformatf("rnd%0d", i), act, exp_m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
